// File: rtl/vga_scan_if.sv
// Display-path signal bundle between the raster-scan controller and its consumers.
// The controller (master) receives the composited pixel and drives the scan position,
// the sync/blank timing and the VGA RGB pins.
interface vga_scan_if;
    logic [11:0] pixel_in;
    logic        pix_tick;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        frame_start;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    modport master (
        input  pixel_in,
        output pix_tick, h_cnt, v_cnt, frame_start, valid, hsync, vsync, vga_r, vga_g, vga_b
    );

    modport slave (
        output pixel_in,
        input  pix_tick, h_cnt, v_cnt, frame_start, valid, hsync, vsync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Raster-scan source: pixel-rate enable from the system clock, h/v coordinate counters,
// sync/blank decode delayed to line up with the pixel returned by the sprite ROMs, and
// the blanked RGB output register.
module vga_scan_ctrl #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    vga_scan_if.master bus
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Counters are 10 bits wide; refuse configurations that cannot be represented.
    generate
        if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 2 || PIPE_DLY < 1) begin : g_bad_cfg
            $error("vga_scan_ctrl: unsupported parameter set");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic [9:0]       h_q;
    logic [9:0]       v_q;
    logic [31:0]      h_ext;
    logic [31:0]      v_ext;
    logic             h_last;
    logic             v_last;
    logic             vis_raw;
    logic             hs_raw;
    logic             vs_raw;
    logic             vis_pre;
    logic [2:0]       pipe_q [PIPE_DLY];  // {vis, hs, vs}; stage 0 holds the raw decode
    logic [11:0]      rgb_q;

    // Pixel-rate divider; tick is registered so it lands one clock after the wrap count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DIV_W'(CLK_DIV - 1));
            div_q  <= (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        end
    end

    // Unsigned decode of the current scan position, done at 32 bits to avoid truncating bounds.
    always_comb begin
        h_ext   = 32'(h_q);
        v_ext   = 32'(v_q);
        h_last  = (h_ext == H_TOT - 1);
        v_last  = (v_ext == V_TOT - 1);
        vis_raw = (h_ext < H_VIS) && (v_ext < V_VIS);
        hs_raw  = !((h_ext >= H_VIS + H_FP) && (h_ext < H_VIS + H_FP + H_SYNC));
        vs_raw  = !((v_ext >= V_VIS + V_FP) && (v_ext < V_VIS + V_FP + V_SYNC));
    end

    // Horizontal/vertical scan counters, advanced once per pixel tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (tick_q) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + 10'd1;
            end else begin
                h_q <= h_q + 10'd1;
            end
        end
    end

    // Sync/visible delay line so timing matches the ROM read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= 3'b011;
        end else if (tick_q) begin
            pipe_q[0] <= {vis_raw, hs_raw, vs_raw};
            for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // The RGB register samples one stage early so it changes on the same clock as valid.
    generate
        if (PIPE_DLY == 1) begin : g_vis_raw
            assign vis_pre = vis_raw;
        end else begin : g_vis_pipe
            assign vis_pre = pipe_q[PIPE_DLY-2][2];
        end
    endgenerate

    // Blanked RGB output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= 12'h000;
        end else if (tick_q) begin
            rgb_q <= vis_pre ? bus.pixel_in : 12'h000;
        end
    end

    assign bus.pix_tick    = tick_q;
    assign bus.h_cnt       = h_q;
    assign bus.v_cnt       = v_q;
    assign bus.frame_start = tick_q & h_last & v_last;
    assign bus.valid       = pipe_q[PIPE_DLY-1][2];
    assign bus.hsync       = pipe_q[PIPE_DLY-1][1];
    assign bus.vsync       = pipe_q[PIPE_DLY-1][0];
    assign bus.vga_r       = rgb_q[11:8];
    assign bus.vga_g       = rgb_q[7:4];
    assign bus.vga_b       = rgb_q[3:0];
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a reduced raster so whole frames fit in a short run.
// A position model derived from elapsed clocks predicts every output on every clock.
module tb_vga_scan_ctrl;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned H_VIS    = 16;
    localparam int unsigned H_FP     = 4;
    localparam int unsigned H_SYNC   = 6;
    localparam int unsigned H_BP     = 6;
    localparam int unsigned V_VIS    = 6;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 3;
    localparam int unsigned PIPE_DLY = 2;
    localparam int unsigned H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME    = H_TOT * V_TOT;
    localparam int unsigned BOUND    = FRAME * CLK_DIV + 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_scan_if bus ();

    vga_scan_ctrl #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .PIPE_DLY(PIPE_DLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tick;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        fs;
        logic        valid;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    typedef struct packed {
        logic [31:0] e;      // clocks since reset release
        logic        tick;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        valid;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned edges    = 0;
    logic [11:0] pix_cur  = 12'h000;
    logic [11:0] pix_const = 12'hA5C;
    logic [11:0] last_pix = 12'h000;
    int          pix_mode = 0;  // 0 constant, 1 random, 2 all-ones

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
        end
    endfunction

    // Expected outputs after e clocks since release: ticks elapsed give the raster position.
    function automatic exp_t model(input int unsigned e, input logic [11:0] lp);
        exp_t r;
        int unsigned n, m, mh, mv;
        n      = (e == 0) ? 0 : (e - 1) / CLK_DIV;
        r.tick = (e != 0) && (e % CLK_DIV == 0);
        r.h    = 10'(n % H_TOT);
        r.v    = 10'((n / H_TOT) % V_TOT);
        r.fs   = r.tick && (n % H_TOT == H_TOT - 1) && ((n / H_TOT) % V_TOT == V_TOT - 1);
        if (n < PIPE_DLY) begin
            r.valid = 1'b0;
            r.hs    = 1'b1;
            r.vs    = 1'b1;
        end else begin
            m       = n - PIPE_DLY;
            mh      = m % H_TOT;
            mv      = (m / H_TOT) % V_TOT;
            r.valid = (mh < H_VIS) && (mv < V_VIS);
            r.hs    = !(mh >= H_VIS + H_FP && mh < H_VIS + H_FP + H_SYNC);
            r.vs    = !(mv >= V_VIS + V_FP && mv < V_VIS + V_FP + V_SYNC);
        end
        r.rgb = r.valid ? lp : 12'h000;
        return r;
    endfunction

    task automatic drive_pix();
        case (pix_mode)
            0:       pix_cur = pix_const;
            1:       pix_cur = 12'($urandom);
            default: pix_cur = 12'hFFF;
        endcase
        bus.pixel_in = pix_cur;
    endtask

    // One clock: advance the model, compare every output, then present the next pixel.
    task automatic step();
        exp_t x;
        @(posedge clk);
        if (rst) begin
            edges++;
            if (edges > 1 && (edges - 1) % CLK_DIV == 0) last_pix = pix_cur;
        end
        #1;
        x = model(edges, last_pix);
        check("pix_tick", 32'(bus.pix_tick), 32'(x.tick));
        check("h_cnt", 32'(bus.h_cnt), 32'(x.h));
        check("v_cnt", 32'(bus.v_cnt), 32'(x.v));
        check("frame_start", 32'(bus.frame_start), 32'(x.fs));
        check("valid", 32'(bus.valid), 32'(x.valid));
        check("hsync", 32'(bus.hsync), 32'(x.hs));
        check("vsync", 32'(bus.vsync), 32'(x.vs));
        check("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(x.rgb));
        drive_pix();
    endtask

    task automatic wait_for(input string name, input int unsigned h, input int unsigned v,
                            input bit need_tick);
        int unsigned i = 0;
        while (i < BOUND && !(32'(bus.h_cnt) == h && 32'(bus.v_cnt) == v &&
                              (!need_tick || bus.pix_tick))) begin
            step();
            i++;
        end
        check(name, 32'(i < BOUND), 32'd1);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < NV; i++) begin
            while (edges < tbl[i].e) step();
            check({tag, "_tick"}, 32'(bus.pix_tick), 32'(tbl[i].tick));
            check({tag, "_h"}, 32'(bus.h_cnt), 32'(tbl[i].h));
            check({tag, "_v"}, 32'(bus.v_cnt), 32'(tbl[i].v));
            check({tag, "_valid"}, 32'(bus.valid), 32'(tbl[i].valid));
            check({tag, "_hsync"}, 32'(bus.hsync), 32'(tbl[i].hs));
            check({tag, "_vsync"}, 32'(bus.vsync), 32'(tbl[i].vs));
            check({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(tbl[i].rgb));
        end
    endtask

    task automatic release_reset();
        pix_mode = 0;
        drive_pix();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int unsigned cnt, i, blank_ticks, blank_bad, fs_cnt;

        // First scan line after release with pixel_in held at 12'hA5C.
        tbl[0] = '{32'd1,  1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[1] = '{32'd4,  1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[2] = '{32'd5,  1'b0, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[3] = '{32'd8,  1'b1, 10'd1, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[4] = '{32'd9,  1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 12'hA5C};
        tbl[5] = '{32'd12, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 12'hA5C};
        tbl[6] = '{32'd13, 1'b0, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 12'hA5C};

        bus.pixel_in = 12'h000;
        #2 rst = 1'b0;
        repeat (3) step();
        release_reset();
        run_table("release");

        pix_mode = 1;
        // Line wrap mid-frame.
        wait_for("line_wrap_reached", H_TOT - 1, 3, 1'b1);
        check("line_wrap_fs", 32'(bus.frame_start), 32'd0);
        step();
        check("line_wrap_h", 32'(bus.h_cnt), 32'd0);
        check("line_wrap_v", 32'(bus.v_cnt), 32'd4);

        // Frame wrap, then one full frame of ticks with a single frame_start.
        wait_for("frame_wrap_reached", H_TOT - 1, V_TOT - 1, 1'b1);
        check("frame_wrap_fs", 32'(bus.frame_start), 32'd1);
        step();
        check("frame_wrap_fs_low", 32'(bus.frame_start), 32'd0);
        check("frame_wrap_h", 32'(bus.h_cnt), 32'd0);
        check("frame_wrap_v", 32'(bus.v_cnt), 32'd0);
        cnt = 0;
        fs_cnt = 0;
        repeat (FRAME * CLK_DIV) begin
            step();
            cnt += 32'(bus.pix_tick);
            fs_cnt += 32'(bus.frame_start);
        end
        check("frame_ticks", cnt, FRAME);
        check("frame_starts", fs_cnt, 1);

        // hsync latency and width.
        wait_for("hs_reached", H_VIS + H_FP, 2, 1'b0);
        cnt = 0;
        i = 0;
        while (bus.hsync === 1'b1 && i < 1000) begin cnt += 32'(bus.pix_tick); step(); i++; end
        check("hsync_delay", cnt, PIPE_DLY);
        cnt = 0;
        i = 0;
        while (bus.hsync === 1'b0 && i < 1000) begin cnt += 32'(bus.pix_tick); step(); i++; end
        check("hsync_width", cnt, H_SYNC);

        // vsync latency and width.
        wait_for("vs_reached", 0, V_VIS + V_FP, 1'b0);
        cnt = 0;
        i = 0;
        while (bus.vsync === 1'b1 && i < 1000) begin cnt += 32'(bus.pix_tick); step(); i++; end
        check("vsync_delay", cnt, PIPE_DLY);
        cnt = 0;
        i = 0;
        while (bus.vsync === 1'b0 && i < 2000) begin cnt += 32'(bus.pix_tick); step(); i++; end
        check("vsync_width", cnt, V_SYNC * H_TOT);

        // Blanking with pixel_in forced to all ones.
        pix_mode = 2;
        blank_ticks = 0;
        blank_bad = 0;
        repeat (FRAME * CLK_DIV) begin
            step();
            if (bus.pix_tick && !bus.valid) blank_ticks++;
            if (!bus.valid && {bus.vga_r, bus.vga_g, bus.vga_b} != 12'h000) blank_bad++;
        end
        check("blank_ticks", blank_ticks, FRAME - H_VIS * V_VIS);
        check("blank_rgb_zero", blank_bad, 0);

        // Asynchronous reset in the middle of a visible line.
        wait_for("mid_reached", 10, 4, 1'b0);
        check("mid_valid_before", 32'(bus.valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_h", 32'(bus.h_cnt), 32'd0);
        check("mid_rst_v", 32'(bus.v_cnt), 32'd0);
        check("mid_rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_hsync", 32'(bus.hsync), 32'd1);
        check("mid_rst_vsync", 32'(bus.vsync), 32'd1);
        check("mid_rst_tick", 32'(bus.pix_tick), 32'd0);
        edges = 0;
        last_pix = 12'h000;
        repeat (5) step();
        release_reset();
        run_table("restart");
        pix_mode = 1;
        repeat (3 * H_TOT * CLK_DIV) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
